// File: rtl/alarm_match_module.sv
// Alarm-register reader: on each minute tick, fetch today's alarm word, compare it with
// the current time, and ring / snooze / stop / time out.
// Latency: MIN_TICK in cycle n -> ALARM high from cycle n+2 (one fetch cycle, one compare cycle).
// No backpressure: STOP/SNOOZE/MIN_TICK are sampled every cycle and take effect at the next edge.
module alarm_match_module #(
  parameter int RING_MINUTES   = 5,  // unanswered ring ticks before auto-off (1..15)
  parameter int SNOOZE_MINUTES = 9   // snooze ticks before re-ring (1..15)
) (
  input  logic        CLK,
  input  logic        CLEAR,
  input  logic [14:0] CTI,
  input  logic [12:0] Q_r0,
  input  logic [12:0] Q_r1,
  input  logic [12:0] Q_r2,
  input  logic [12:0] Q_r3,
  input  logic [12:0] Q_r4,
  input  logic [12:0] Q_r5,
  input  logic [12:0] Q_r6,
  input  logic        MIN_TICK,
  input  logic        STOP,
  input  logic        SNOOZE,
  output logic        ALARM,
  output logic        SNOOZING,
  output logic [2:0]  RING_DAY
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_RING    = 2'd2,
    S_SNZ     = 2'd3
  } state_t;

  // Counter limits held in the 4-bit counter width.
  localparam logic [3:0] RING_LIM = 4'(RING_MINUTES);
  localparam logic [3:0] SNZ_INIT = 4'(SNOOZE_MINUTES);

  state_t      r_state;
  logic [14:0] r_cti_q;
  logic [12:0] r_word_q;
  logic [3:0]  r_ring_cnt;
  logic [3:0]  r_snz_cnt;
  logic        r_alarm;
  logic        r_snoozing;
  logic [2:0]  r_ring_day;

  logic [12:0] w_day_word;     // alarm word for the day currently shown on CTI
  logic [12:0] w_ring_word;    // alarm word for the day that is ringing/snoozed
  logic        w_ring_enabled;
  logic        w_match;
  logic [3:0]  w_ring_cnt_inc;
  logic        w_ring_timeout;
  logic        w_snz_expire;

  // Select the alarm word for the current CTI day; day 7 has no register and reads as off.
  always_comb begin
    w_day_word = 13'd0;
    case (CTI[14:12])
      3'd0:    w_day_word = Q_r0;
      3'd1:    w_day_word = Q_r1;
      3'd2:    w_day_word = Q_r2;
      3'd3:    w_day_word = Q_r3;
      3'd4:    w_day_word = Q_r4;
      3'd5:    w_day_word = Q_r5;
      3'd6:    w_day_word = Q_r6;
      default: w_day_word = 13'd0;
    endcase
  end

  // Live view of the ringing day's word so a user disabling it cancels the ring at once.
  always_comb begin
    w_ring_word = 13'd0;
    case (r_ring_day)
      3'd0:    w_ring_word = Q_r0;
      3'd1:    w_ring_word = Q_r1;
      3'd2:    w_ring_word = Q_r2;
      3'd3:    w_ring_word = Q_r3;
      3'd4:    w_ring_word = Q_r4;
      3'd5:    w_ring_word = Q_r5;
      3'd6:    w_ring_word = Q_r6;
      default: w_ring_word = 13'd0;
    endcase
  end

  assign w_ring_enabled = w_ring_word[12];
  // Hour and BCD minutes compared bit-for-bit; seconds are never looked at.
  assign w_match        = r_word_q[12] && (r_word_q[11:0] == r_cti_q[11:0]);
  assign w_ring_cnt_inc = r_ring_cnt + 4'd1;
  assign w_ring_timeout = (w_ring_cnt_inc == RING_LIM);
  // Snooze ends on the tick that takes the count to zero; guard against an already-zero count.
  assign w_snz_expire   = (r_snz_cnt <= 4'd1);

  // Alarm FSM with its counters and registered outputs; outputs follow the state entered.
  always_ff @(posedge CLK) begin
    if (CLEAR) begin
      r_state    <= S_IDLE;
      r_cti_q    <= 15'd0;
      r_word_q   <= 13'd0;
      r_ring_cnt <= 4'd0;
      r_snz_cnt  <= 4'd0;
      r_alarm    <= 1'b0;
      r_snoozing <= 1'b0;
      r_ring_day <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_alarm    <= 1'b0;
          r_snoozing <= 1'b0;
          if (MIN_TICK) begin
            r_cti_q  <= CTI;
            r_word_q <= w_day_word;
            r_state  <= S_COMPARE;
          end
        end

        S_COMPARE: begin
          if (w_match) begin
            r_state    <= S_RING;
            r_ring_day <= r_cti_q[14:12];
            r_ring_cnt <= 4'd0;
            r_alarm    <= 1'b1;
          end else begin
            r_state    <= S_IDLE;
          end
        end

        S_RING: begin
          if (STOP || !w_ring_enabled) begin
            r_state <= S_IDLE;
            r_alarm <= 1'b0;
          end else if (SNOOZE) begin
            r_state    <= S_SNZ;
            r_snz_cnt  <= SNZ_INIT;
            r_alarm    <= 1'b0;
            r_snoozing <= 1'b1;
          end else if (MIN_TICK) begin
            r_ring_cnt <= w_ring_cnt_inc;
            if (w_ring_timeout) begin
              r_state <= S_IDLE;
              r_alarm <= 1'b0;
            end
          end
        end

        S_SNZ: begin
          // SNOOZE has no effect here; the snooze period is not extended.
          if (STOP || !w_ring_enabled) begin
            r_state    <= S_IDLE;
            r_snoozing <= 1'b0;
          end else if (MIN_TICK) begin
            if (w_snz_expire) begin
              r_snz_cnt  <= 4'd0;
              r_ring_cnt <= 4'd0;
              r_state    <= S_RING;
              r_snoozing <= 1'b0;
              r_alarm    <= 1'b1;
            end else begin
              r_snz_cnt  <= r_snz_cnt - 4'd1;
            end
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_alarm    <= 1'b0;
          r_snoozing <= 1'b0;
        end
      endcase
    end
  end

  assign ALARM    = r_alarm;
  assign SNOOZING = r_snoozing;
  assign RING_DAY = r_ring_day;

endmodule

// File: tb/tb_alarm_match_module.sv
module tb_alarm_match_module;

  localparam int RING_M = 5;
  localparam int SNZ_M  = 9;

  logic        clk;
  logic        CLEAR;
  logic [14:0] CTI;
  logic [12:0] qr [0:6];
  logic        MIN_TICK, STOP, SNOOZE;
  logic        ALARM, SNOOZING;
  logic [2:0]  RING_DAY;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  alarm_match_module #(.RING_MINUTES(RING_M), .SNOOZE_MINUTES(SNZ_M)) dut (
    .CLK(clk), .CLEAR(CLEAR), .CTI(CTI),
    .Q_r0(qr[0]), .Q_r1(qr[1]), .Q_r2(qr[2]), .Q_r3(qr[3]),
    .Q_r4(qr[4]), .Q_r5(qr[5]), .Q_r6(qr[6]),
    .MIN_TICK(MIN_TICK), .STOP(STOP), .SNOOZE(SNOOZE),
    .ALARM(ALARM), .SNOOZING(SNOOZING), .RING_DAY(RING_DAY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Mode: 0 idle, 1 waiting on compare, 2 ringing, 3 snoozing.
  int          m_mode = 0;
  logic [12:0] m_word;
  logic [14:0] m_cti;
  int          m_ring_left, m_snz_left;
  logic [2:0]  m_day = 3'd0;

  function automatic logic [12:0] word_of(input logic [2:0] d);
    if (d == 3'd7) return 13'd0;
    return qr[d];
  endfunction

  // Time equality in plain numbers: hours, and minutes as tens*10+units.
  function automatic bit time_hits(input logic [12:0] w, input logic [14:0] t);
    int wh, wm, th, tm;
    wh = int'(w[11:7]); wm = int'(w[6:4]) * 10 + int'(w[3:0]);
    th = int'(t[11:7]); tm = int'(t[6:4]) * 10 + int'(t[3:0]);
    return w[12] && (wh == th) && (wm == tm);
  endfunction

  always @(posedge clk) begin
    if (CLEAR) begin
      m_mode = 0; m_day = 3'd0; m_ring_left = 0; m_snz_left = 0;
    end else begin
      case (m_mode)
        0: if (MIN_TICK) begin
             m_cti = CTI; m_word = word_of(CTI[14:12]); m_mode = 1;
           end
        1: if (time_hits(m_word, m_cti)) begin
             m_mode = 2; m_day = m_cti[14:12]; m_ring_left = RING_M;
           end else m_mode = 0;
        2: if (STOP || !word_of(m_day)[12]) m_mode = 0;
           else if (SNOOZE) begin m_mode = 3; m_snz_left = SNZ_M; end
           else if (MIN_TICK) begin
             m_ring_left--;
             if (m_ring_left == 0) m_mode = 0;
           end
        3: if (STOP || !word_of(m_day)[12]) m_mode = 0;
           else if (MIN_TICK) begin
             m_snz_left--;
             if (m_snz_left <= 0) begin m_mode = 2; m_ring_left = RING_M; end
           end
        default: m_mode = 0;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_alarm",    32'(ALARM),    32'(m_mode == 2));
      chk("model_snoozing", 32'(SNOOZING), 32'(m_mode == 3));
      chk("model_ring_day", 32'(RING_DAY), 32'(m_day));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic tick();
    MIN_TICK = 1'b1; cyc(1); MIN_TICK = 1'b0;
  endtask

  function automatic logic [14:0] mk_cti(input int d, input int h, input int tens, input int units);
    return {3'(d), 5'(h), 3'(tens), 4'(units)};
  endfunction

  initial begin
    CLEAR = 1'b1; CTI = '0; MIN_TICK = 0; STOP = 0; SNOOZE = 0;
    for (int i = 0; i < 7; i++) qr[i] = 13'd0;
    cyc(2);
    chk_en = 1'b1;
    CLEAR = 1'b0;
    chk("reset_alarm", 32'(ALARM), 0);
    chk("reset_snoozing", 32'(SNOOZING), 0);
    chk("reset_ring_day", 32'(RING_DAY), 0);

    // Basic match and two-cycle latency.
    qr[2] = 13'h14A7;
    CTI = mk_cti(2, 9, 2, 7);
    tick();
    chk("latency_n1_alarm", 32'(ALARM), 0);
    cyc(1);
    chk("match_alarm", 32'(ALARM), 1);
    chk("match_ring_day", 32'(RING_DAY), 2);

    // STOP and SNOOZE together: STOP wins.
    STOP = 1; SNOOZE = 1; cyc(1); STOP = 0; SNOOZE = 0;
    chk("stop_snz_alarm", 32'(ALARM), 0);
    chk("stop_snz_snoozing", 32'(SNOOZING), 0);

    // Snooze for nine ticks, then re-ring.
    tick(); cyc(1);
    chk("rering_alarm", 32'(ALARM), 1);
    SNOOZE = 1; cyc(1); SNOOZE = 0;
    chk("snooze_enter", 32'(SNOOZING), 1);
    chk("snooze_alarm_off", 32'(ALARM), 0);
    for (int i = 1; i <= 9; i++) begin
      cyc(1); tick();
      if (i < 9) chk("snooze_hold", 32'(SNOOZING), 1);
    end
    chk("snooze_done_alarm", 32'(ALARM), 1);
    chk("snooze_done_snoozing", 32'(SNOOZING), 0);

    // Auto-timeout after five unanswered ticks.
    for (int i = 1; i <= 5; i++) begin
      cyc(1); tick();
      if (i < 5) chk("timeout_hold", 32'(ALARM), 1);
    end
    chk("timeout_alarm", 32'(ALARM), 0);
    CTI = mk_cti(2, 9, 2, 8);
    tick(); cyc(1);
    chk("tick6_nomatch", 32'(ALARM), 0);
    chk("ring_day_kept", 32'(RING_DAY), 2);

    // Non-matching cases.
    qr[2] = 13'h04A7; CTI = mk_cti(2, 9, 2, 7);
    tick(); cyc(1);
    chk("disabled_nomatch", 32'(ALARM), 0);
    qr[2] = 13'h14A7; CTI = mk_cti(2, 9, 2, 8);
    tick(); cyc(1);
    chk("minute_nomatch", 32'(ALARM), 0);
    CTI = mk_cti(3, 9, 2, 7);
    tick(); cyc(1);
    chk("day_nomatch", 32'(ALARM), 0);
    CTI = mk_cti(7, 9, 2, 7);
    tick(); cyc(1);
    chk("day7_nomatch", 32'(ALARM), 0);

    // CLEAR while ringing.
    CTI = mk_cti(2, 9, 2, 7);
    tick(); cyc(1);
    chk("pre_clear_ring", 32'(ALARM), 1);
    CLEAR = 1; cyc(1); CLEAR = 0;
    chk("clear_ring_alarm", 32'(ALARM), 0);
    chk("clear_ring_day", 32'(RING_DAY), 0);

    // CLEAR while snoozing.
    tick(); cyc(1);
    SNOOZE = 1; cyc(1); SNOOZE = 0;
    chk("pre_clear_snz", 32'(SNOOZING), 1);
    CLEAR = 1; cyc(1); CLEAR = 0;
    chk("clear_snz_snoozing", 32'(SNOOZING), 0);
    chk("clear_snz_alarm", 32'(ALARM), 0);
    chk("clear_snz_day", 32'(RING_DAY), 0);

    // Disabling the word mid-ring cancels it.
    tick(); cyc(1);
    qr[2] = 13'h04A7; cyc(1);
    chk("disable_midring", 32'(ALARM), 0);

    // Randomized traffic checked by the per-cycle model comparison.
    for (int c = 0; c < 4000; c++) begin
      CLEAR    = ($urandom_range(0, 299) == 0);
      STOP     = ($urandom_range(0, 39) == 0);
      SNOOZE   = ($urandom_range(0, 19) == 0);
      MIN_TICK = ($urandom_range(0, 2) == 0);
      if (MIN_TICK) begin
        int d;
        d = int'($urandom_range(0, 7));
        CTI = mk_cti(d, int'($urandom_range(0, 23)), int'($urandom_range(0, 5)),
                     int'($urandom_range(0, 9)));
        if (d < 7 && $urandom_range(0, 1) == 1)
          qr[d] = {1'($urandom_range(0, 3) != 0), CTI[11:0]};
      end
      if ($urandom_range(0, 79) == 0) begin
        int k;
        k = int'($urandom_range(0, 6));
        qr[k][12] = ~qr[k][12];
      end
      cyc(1);
    end
    CLEAR = 0; STOP = 0; SNOOZE = 0; MIN_TICK = 0;
    cyc(2);
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
